ccff_chain_loader: RTL and testbench

Configuration-chain loader for the fabric's configuration flip-flop chain. It accepts bitstream words over a valid/ready handshake, serializes them MSB-first onto the chain head, and asserts one shift-enable per bit until exactly `CHAIN_LENGTH` bits have been shifted. It sits at the driving end of the chain, upstream of the first tile's `ccff_head`. The last tile's `ccff_tail` returns to this block for an optional integrity check.

---
 rtl/ccff_chain_loader.sv | 152 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream words MSB-first onto the ccff chain head.
// Optional tail integrity check enabled by defining CCFF_TAIL_CHECK_EN.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LENGTH = 1024,
    parameter int unsigned WORD_WIDTH   = 8
) (
    input  logic                  prog_clk,
    input  logic                  pReset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] bs_data,
    input  logic                  bs_valid,
    output logic                  bs_ready,
    output logic                  ccff_head,
    output logic                  shift_en,
    input  logic                  ccff_tail,
    output logic                  busy,
    output logic                  done,
    output logic                  tail_err
);

    localparam int unsigned REM_W = $clog2(CHAIN_LENGTH + 1);
    localparam int unsigned WB_W  = $clog2(WORD_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [REM_W-1:0]       rem_q, rem_d;
    logic [WORD_WIDTH-1:0]  sreg_q, sreg_d;
    logic [WB_W-1:0]        wbits_q, wbits_d;
    logic                   head_q, head_d;
    logic                   shen_q, shen_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Counters hold the bits still to present, including the one on ccff_head this cycle.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sreg_d  = sreg_q;
        wbits_d = wbits_q;
        head_d  = head_q;
        shen_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    rem_d   = REM_W'(CHAIN_LENGTH);
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bs_valid) begin
                    head_d  = bs_data[WORD_WIDTH-1];
                    sreg_d  = bs_data << 1;
                    shen_d  = 1'b1;
                    state_d = S_SHIFT;
                    if (32'(rem_q) >= WORD_WIDTH) begin
                        wbits_d = WB_W'(WORD_WIDTH);
                    end else begin
                        wbits_d = WB_W'(rem_q);
                    end
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    wbits_d = wbits_q - WB_W'(1);
                    rem_d   = rem_q - REM_W'(1);
                    if (wbits_q == WB_W'(1)) begin
                        state_d = (rem_q == REM_W'(1)) ? S_DONE : S_LOAD;
                    end else begin
                        head_d = sreg_q[WORD_WIDTH-1];
                        sreg_d = sreg_q << 1;
                        shen_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d == S_LOAD) || (state_d == S_SHIFT);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            sreg_q  <= '0;
            wbits_q <= '0;
            head_q  <= 1'b0;
            shen_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sreg_q  <= sreg_d;
            wbits_q <= wbits_d;
            head_q  <= head_d;
            shen_q  <= shen_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bs_ready  = ready_q;
    assign ccff_head = head_q;
    assign shift_en  = shen_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef CCFF_TAIL_CHECK_EN
    logic err_q, err_d;

    // Chain is all-zero after reset, so any 1 seen at the tail while shifting is an error.
    always_comb begin
        err_d = err_q;
        if (start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            err_d = 1'b0;
        end else if (shen_q && ccff_tail) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign tail_err = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign tail_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: two instances (16-bit and 20-bit chains) checked
// against a bit-queue reference model of the serialized bitstream.
module tb_ccff_chain_loader;

    localparam int unsigned W   = 8;
    localparam int unsigned CLA = 16;
    localparam int unsigned CLB = 20;
    localparam int          TMO = 400;
`ifdef CCFF_TAIL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [1:0]   start, abort, valid, tail;
    logic [1:0]   ready, head, sen, busy, done, err;
    logic [W-1:0] data_a, data_b;
    logic [W-1:0] wq [8];
    int           vectors;
    int           miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ccff_chain_loader #(.CHAIN_LENGTH(CLA), .WORD_WIDTH(W)) u_a (
        .prog_clk(clk), .pReset_n(rst_n), .start(start[0]), .abort(abort[0]),
        .bs_data(data_a), .bs_valid(valid[0]), .bs_ready(ready[0]),
        .ccff_head(head[0]), .shift_en(sen[0]), .ccff_tail(tail[0]),
        .busy(busy[0]), .done(done[0]), .tail_err(err[0])
    );

    ccff_chain_loader #(.CHAIN_LENGTH(CLB), .WORD_WIDTH(W)) u_b (
        .prog_clk(clk), .pReset_n(rst_n), .start(start[1]), .abort(abort[1]),
        .bs_data(data_b), .bs_valid(valid[1]), .bs_ready(ready[1]),
        .ccff_head(head[1]), .shift_en(sen[1]), .ccff_tail(tail[1]),
        .busy(busy[1]), .done(done[1]), .tail_err(err[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: concatenate words MSB-first and keep the first cl bits.
    function automatic logic [63:0] model(input int cl, input int nw);
        logic [63:0] r;
        int          cnt;
        r   = '0;
        cnt = 0;
        for (int w = 0; w < nw; w++) begin
            for (int b = W - 1; b >= 0; b--) begin
                if (cnt < cl) begin
                    r = {r[62:0], wq[w][b]};
                    cnt++;
                end
            end
        end
        return r;
    endfunction

    function automatic int exp_cycles(input int cl);
        return cl + (cl + W - 1) / W;
    endfunction

    task automatic set_data(input int s, input logic [W-1:0] v);
        if (s == 0) data_a = v;
        else        data_b = v;
    endtask

    task automatic run_load(input int s, input int stall2, input int abort_at, input int rst_at,
                            input int tail_at, input int restart_at,
                            output int cyc, output int npulse, output int nready,
                            output logic [63:0] bits);
        int idx;
        int stalled;
        @(negedge clk);
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
        chk($sformatf("start_done_clr%0d", s), 64'(done[s]), 64'd0);
        chk($sformatf("start_busy%0d", s), 64'(busy[s]), 64'd1);
        chk($sformatf("start_err_clr%0d", s), 64'(err[s]), 64'd0);
        cyc = 0; idx = 0; stalled = 0; npulse = 0; nready = 0; bits = '0;
        while (cyc < TMO) begin
            if (done[s]) break;
            if (sen[s]) begin
                npulse++;
                bits = {bits[62:0], head[s]};
            end
            if (ready[s]) nready++;
            tail[s]  = 1'b0;
            valid[s] = 1'b0;
            abort[s] = 1'b0;
            start[s] = 1'b0;
            set_data(s, W'($urandom));
            if (ready[s]) begin
                if (idx == 1 && stalled < stall2) begin
                    chk("stall_sen", 64'(sen[s]), 64'd0);
                    stalled++;
                end else begin
                    valid[s] = 1'b1;
                    set_data(s, wq[idx]);
                    idx++;
                end
            end
            if (sen[s] && npulse == tail_at)    tail[s]  = 1'b1;
            if (sen[s] && npulse == restart_at) start[s] = 1'b1;
            if (sen[s] && npulse == abort_at) begin
                abort[s] = 1'b1;
                break;
            end
            if (sen[s] && npulse == rst_at) begin
                rst_n = 1'b0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= TMO) chk("load_timeout", 64'(cyc), 64'd0);
        valid[s] = 1'b0;
        tail[s]  = 1'b0;
        start[s] = 1'b0;
    endtask

    initial begin
        int          cyc, np, nr, extra;
        logic [63:0] bits;
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = '0; abort = '0; valid = '0; tail = '0;
        data_a = '0; data_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_head",  64'(head),  64'd0);
        chk("rst_sen",   64'(sen),   64'd0);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_err",   64'(err),   64'd0);
        rst_n = 1'b1;

        // Full words on the 16-bit chain.
        wq[0] = 8'hA5; wq[1] = 8'h3C;
        run_load(0, 0, -1, -1, -1, -1, cyc, np, nr, bits);
        chk("full_bits", bits, 64'hA53C);
        chk("full_pulses", 64'(np), 64'(CLA));
        chk("full_cycles", 64'(cyc), 64'd18);
        chk("full_ready", 64'(nr), 64'd2);
        chk("full_busy_done", 64'({busy[0], done[0], sen[0], ready[0]}), 64'b0100);

        // Partial last word on the 20-bit chain.
        wq[0] = 8'hFF; wq[1] = 8'h00; wq[2] = 8'hF0;
        run_load(1, 0, -1, -1, -1, -1, cyc, np, nr, bits);
        chk("part_bits", bits, model(CLB, 3));
        chk("part_last4", 64'(bits[3:0]), 64'hF);
        chk("part_pulses", 64'(np), 64'(CLB));
        chk("part_ready", 64'(nr), 64'd3);
        chk("part_cycles", 64'(cyc), 64'(exp_cycles(CLB)));

        // Stall of 5 cycles before the second word.
        wq[0] = 8'hA5; wq[1] = 8'h3C;
        run_load(0, 5, -1, -1, -1, -1, cyc, np, nr, bits);
        chk("stall_bits", bits, 64'hA53C);
        chk("stall_pulses", 64'(np), 64'(CLA));
        chk("stall_ready", 64'(nr), 64'd7);
        chk("stall_cycles", 64'(cyc), 64'd23);

        // Abort after 5 pulses.
        run_load(0, 0, 5, -1, -1, -1, cyc, np, nr, bits);
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_state", 64'({busy[0], done[0], sen[0], ready[0]}), 64'd0);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (sen[0]) extra++;
        end
        chk("abort_extra", 64'(extra), 64'd0);
        chk("abort_pulses", 64'(np), 64'd5);

        // Reset mid-SHIFT.
        wq[0] = 8'hFF; wq[1] = 8'hFF;
        run_load(0, 0, -1, 5, -1, -1, cyc, np, nr, bits);
        @(negedge clk);
        chk("mrst_outs", 64'({ready, head, sen, busy, done, err}), 64'd0);
        rst_n = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (sen[0]) extra++;
        end
        chk("mrst_extra", 64'(extra), 64'd0);

        // Start while busy is ignored; start in DONE reloads.
        wq[0] = 8'h96; wq[1] = 8'h0F;
        run_load(0, 0, -1, -1, -1, 8, cyc, np, nr, bits);
        chk("ign_bits", bits, 64'h960F);
        chk("ign_pulses", 64'(np), 64'(CLA));
        chk("ign_cycles", 64'(cyc), 64'd18);
        wq[0] = 8'h5A; wq[1] = 8'hC3;
        run_load(0, 0, -1, -1, -1, -1, cyc, np, nr, bits);
        chk("rel_bits", bits, 64'h5AC3);
        chk("rel_pulses", 64'(np), 64'(CLA));

        // Tail sampled high on the 7th pulse.
        wq[0] = 8'h12; wq[1] = 8'h34; wq[2] = 8'h56;
        run_load(1, 0, -1, -1, 7, -1, cyc, np, nr, bits);
        chk("tail_err_done", 64'(err[1]), 64'(EXP_ERR));
        chk("tail_pulses", 64'(np), 64'(CLB));
        repeat (3) @(negedge clk);
        chk("tail_err_hold", 64'(err[1]), 64'(EXP_ERR));

        // Randomized loads against the model.
        for (int it = 0; it < 6; it++) begin
            int s, cl, nw, st;
            s  = it % 2;
            cl = (s == 0) ? CLA : CLB;
            nw = (cl + W - 1) / W;
            st = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) wq[k] = W'($urandom);
            run_load(s, st, -1, -1, -1, -1, cyc, np, nr, bits);
            chk($sformatf("rnd%0d_bits", it), bits, model(cl, nw));
            chk($sformatf("rnd%0d_pulses", it), 64'(np), 64'(cl));
            chk($sformatf("rnd%0d_cycles", it), 64'(cyc), 64'(exp_cycles(cl) + st));
            chk($sformatf("rnd%0d_ready", it), 64'(nr), 64'(nw + st));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
